// File: rtl/fpu_norm_round.sv
// rtl/fpu_norm_round.sv - single-precision post-add normalise and round-to-nearest-even stage
// Normalises the adder significand one bit per cycle, rounds, and packs the IEEE-754 word.
module fpu_norm_round (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        sign_in,
  input  logic [7:0]  exp_in,
  input  logic [26:0] mant_in,
  input  logic        carry_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        overflow,
  output logic        underflow,
  output logic        inexact
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state, state_nx;

  logic        sign_r;
  logic [8:0]  exp_r;
  logic [26:0] mant_r;
  logic [31:0] result_r;
  logic        overflow_r;
  logic        underflow_r;
  logic        inexact_r;

  logic        capture;
  logic        in_zero;
  logic        in_norm_done;
  logic [26:0] mant_sh;
  logic [8:0]  exp_dec;
  logic        shift_done;

  logic        guard_b;
  logic        round_b;
  logic        sticky_b;
  logic        round_up;
  logic [24:0] sig25;
  logic [23:0] sig24;
  logic [8:0]  exp_fin;
  logic [7:0]  exp_field;
  logic [31:0] res_c;
  logic        ovf_c;
  logic        unf_c;
  logic        inx_c;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign result    = result_r;
  assign overflow  = overflow_r;
  assign underflow = underflow_r;
  assign inexact   = inexact_r;

  assign capture = in_ready && in_valid;
  assign in_zero = (mant_in == 27'd0);

  // Stop shifting as soon as the shifted value is normalised or the exponent has
  // bottomed out, so each SHIFT cycle does real work and n shifts cost n cycles.
  assign in_norm_done = mant_in[26] || (exp_in <= 8'd1);
  assign mant_sh      = {mant_r[25:0], 1'b0};
  assign exp_dec      = exp_r - 9'd1;
  assign shift_done   = mant_sh[26] || (exp_dec <= 9'd1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (in_valid) begin
          if (carry_in) begin
            state_nx = ROUND;
          end else if (in_zero) begin
            state_nx = DONE;
          end else if (in_norm_done) begin
            state_nx = ROUND;
          end else begin
            state_nx = SHIFT;
          end
        end
      end
      SHIFT: begin
        if (shift_done) begin
          state_nx = ROUND;
        end
      end
      ROUND: begin
        state_nx = DONE;
      end
      DONE: begin
        if (out_ready) begin
          state_nx = IDLE;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // Round-to-nearest-even on the 24-bit significand held in mant_r[26:3].
  always_comb begin
    guard_b   = mant_r[2];
    round_b   = mant_r[1];
    sticky_b  = mant_r[0];
    round_up  = guard_b && (round_b || sticky_b || mant_r[3]);
    sig25     = {1'b0, mant_r[26:3]} + {24'd0, round_up};
    sig24     = sig25[24] ? 24'h800000 : sig25[23:0];
    exp_fin   = exp_r + {8'd0, sig25[24]};
    inx_c     = guard_b || round_b || sticky_b;
    exp_field = 8'd0;
    res_c     = 32'd0;
    ovf_c     = 1'b0;
    unf_c     = 1'b0;
    if (exp_fin >= 9'd255) begin
      res_c = {sign_r, 8'hFF, 23'd0};
      ovf_c = 1'b1;
      inx_c = 1'b1;
    end else if (!sig24[23]) begin
      res_c = {sign_r, 8'd0, sig24[22:0]};
      unf_c = inx_c;
    end else begin
      // A significand that reached the hidden bit from exponent 0 is still the smallest normal.
      exp_field = (exp_fin[7:0] == 8'd0) ? 8'd1 : exp_fin[7:0];
      res_c     = {sign_r, exp_field, sig24[22:0]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sign_r      <= 1'b0;
      exp_r       <= 9'd0;
      mant_r      <= 27'd0;
      result_r    <= 32'd0;
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
      inexact_r   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (capture) begin
            sign_r <= sign_in;
            if (carry_in) begin
              mant_r <= {1'b1, mant_in[26:2], mant_in[1] | mant_in[0]};
              exp_r  <= {1'b0, exp_in} + 9'd1;
            end else begin
              mant_r <= mant_in;
              exp_r  <= {1'b0, exp_in};
              if (in_zero) begin
                result_r    <= 32'd0;
                overflow_r  <= 1'b0;
                underflow_r <= 1'b0;
                inexact_r   <= 1'b0;
              end
            end
          end
        end
        SHIFT: begin
          mant_r <= mant_sh;
          exp_r  <= exp_dec;
        end
        ROUND: begin
          result_r    <= res_c;
          overflow_r  <= ovf_c;
          underflow_r <= unf_c;
          inexact_r   <= inx_c;
        end
        default: begin
        end
      endcase
    end
  end

endmodule
